// File: rtl/intr_ctrl.sv
// Interrupt controller: edge-latched requests, priority arbitration,
// pipeline take handshake and a nesting stack restored by eret.
module intr_ctrl #(
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0010,
    parameter int          DEPTH      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  intr_req,
    input  logic [31:0] sta_in,
    input  logic [31:0] pc_commit,
    input  logic        pipe_ready,
    input  logic        eret,
    output logic        irq_out,
    output logic        intr_take,
    output logic [31:0] intr_vector,
    output logic [31:0] ret_pc,
    output logic        eret_done,
    output logic [31:0] sta_out,
    output logic        sta_write,
    output logic [3:0]  pending,
    output logic [2:0]  depth
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state, state_nx;
    logic [3:0]  prev_req, pend_q, elig, low;
    logic [2:0]  depth_q, top;
    logic [1:0]  win;
    logic        can_go, eret_ok, take;
    logic [1:0]  lvl_q [DEPTH];
    logic [3:0]  msk_q [DEPTH];
    logic [31:0] epc_q [DEPTH];
    logic        unused_sta;

    assign unused_sta = ^sta_in[31:8];
    assign elig       = pend_q & sta_in[3:0];

    always_comb begin
        win = 2'd0;
        priority case (1'b1)
            elig[3]: win = 2'd3;
            elig[2]: win = 2'd2;
            elig[1]: win = 2'd1;
            default: win = 2'd0;
        endcase
    end

    assign can_go  = (elig != 4'd0) && (depth_q < 3'(DEPTH));
    assign eret_ok = rst && eret && (depth_q != 3'd0);
    // eret always has priority over a take in the same cycle
    assign take    = rst && (state == WAIT) && can_go
                     && pipe_ready && !eret_ok;
    assign top     = depth_q - 3'd1;
    assign low     = 4'((5'd2 << win) - 5'd1);

    always_comb begin
        irq_out     = rst && (state == WAIT);
        intr_take   = 1'b0;
        intr_vector = 32'd0;
        sta_write   = 1'b0;
        sta_out     = 32'd0;
        eret_done   = 1'b0;
        ret_pc      = 32'd0;
        if (eret_ok) begin
            sta_write = 1'b1;
            eret_done = 1'b1;
            ret_pc    = epc_q[top[AW-1:0]];
            sta_out   = {24'd0,
                         sta_in[7:4] & ~(4'd1 << lvl_q[top[AW-1:0]]),
                         msk_q[top[AW-1:0]]};
        end else if (take) begin
            intr_take   = 1'b1;
            intr_vector = VEC_BASE + 32'(win) * VEC_STRIDE;
            sta_write   = 1'b1;
            // mask the taken level and every level below it
            sta_out     = {24'd0,
                           sta_in[7:4] | (4'd1 << win),
                           sta_in[3:0] & ~low};
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (can_go && !eret_ok) state_nx = WAIT;
            WAIT:    if (eret_ok || !can_go || pipe_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            prev_req <= 4'd0;
            pend_q   <= 4'd0;
            depth_q  <= 3'd0;
        end else begin
            state    <= state_nx;
            prev_req <= intr_req;
            // a fresh edge beats the take clear on the same level
            pend_q   <= (pend_q & ~(take ? (4'd1 << win) : 4'd0))
                        | (intr_req & ~prev_req);
            if (eret_ok)
                depth_q <= top;
            else if (take)
                depth_q <= depth_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (take) begin
            lvl_q[depth_q[AW-1:0]] <= win;
            msk_q[depth_q[AW-1:0]] <= sta_in[3:0];
            epc_q[depth_q[AW-1:0]] <= pc_commit;
        end
    end

    assign pending = pend_q;
    assign depth   = depth_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: directed scenarios plus random traffic, all
// checked each cycle against a queue-based reference model.
module tb_intr_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  req;
    logic [31:0] status;
    logic [31:0] pc;
    logic        pr;
    logic        er;
    logic        irq_out, intr_take, eret_done, sta_write;
    logic [31:0] intr_vector, ret_pc, sta_out;
    logic [3:0]  pending;
    logic [2:0]  depth;

    int compared = 0;
    int mism     = 0;

    always #5 clk = ~clk;

    intr_ctrl dut (
        .clk        (clk),
        .rst        (rstn),
        .intr_req   (req),
        .sta_in     (status),
        .pc_commit  (pc),
        .pipe_ready (pr),
        .eret       (er),
        .irq_out    (irq_out),
        .intr_take  (intr_take),
        .intr_vector(intr_vector),
        .ret_pc     (ret_pc),
        .eret_done  (eret_done),
        .sta_out    (sta_out),
        .sta_write  (sta_write),
        .pending    (pending),
        .depth      (depth)
    );

    typedef struct packed {
        logic [1:0]  lvl;
        logic [3:0]  msk;
        logic [31:0] epc;
    } ent_t;

    ent_t       stk[$];
    logic [3:0] m_pend = 4'd0;
    logic [3:0] m_prev = 4'd0;
    bit         m_wait = 1'b0;

    logic        o_irq, o_take, o_sw, o_done;
    logic [31:0] o_vec, o_sta, o_ret;
    logic [3:0]  o_pend;
    logic [2:0]  o_depth;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [3:0]  elig;
        int          w, s, m;
        bit          er_ok, go, tk;
        logic        e_irq, e_take, e_sw, e_done;
        logic [31:0] e_vec, e_sta, e_ret;
        ent_t        t;
        #1;
        elig = m_pend & status[3:0];
        w = 0;
        for (int k = 0; k < 4; k++) if (elig[k]) w = k;
        er_ok = er && (stk.size() > 0);
        go    = (elig != 0) && (stk.size() < 4);
        tk    = rstn && m_wait && go && pr && !er_ok;
        e_irq = 0; e_take = 0; e_sw = 0; e_done = 0;
        e_vec = 0; e_sta = 0; e_ret = 0;
        if (rstn) begin
            e_irq = m_wait;
            if (er_ok) begin
                t = stk[$];
                s = int'(status[7:4]) & ~(1 << t.lvl) & 15;
                e_sw = 1; e_done = 1; e_ret = t.epc;
                e_sta = 32'(s * 16 + int'(t.msk));
            end else if (tk) begin
                s = (int'(status[7:4]) | (1 << w)) & 15;
                m = int'(status[3:0]) & ~((2 << w) - 1) & 15;
                e_take = 1; e_sw = 1;
                e_vec = 32'(256 + w * 16);
                e_sta = 32'(s * 16 + m);
            end
        end
        o_irq = irq_out; o_take = intr_take; o_vec = intr_vector;
        o_sw = sta_write; o_sta = sta_out; o_done = eret_done;
        o_ret = ret_pc; o_pend = pending; o_depth = depth;
        chk("irq_out", o_irq, e_irq);
        chk("intr_take", o_take, e_take);
        chk("intr_vector", o_vec, e_vec);
        chk("sta_write", o_sw, e_sw);
        chk("sta_out", o_sta, e_sta);
        chk("eret_done", o_done, e_done);
        chk("ret_pc", o_ret, e_ret);
        chk("pending", o_pend, m_pend);
        chk("depth", o_depth, 32'(stk.size()));
        @(posedge clk);
        #1;
        if (!rstn) begin
            m_pend = 0; m_prev = 0; m_wait = 0;
            stk.delete();
        end else begin
            if (tk) m_pend[w] = 1'b0;
            m_pend = m_pend | (req & ~m_prev);
            m_prev = req;
            if (er_ok) void'(stk.pop_back());
            else if (tk) stk.push_back('{lvl: 2'(w), msk: status[3:0],
                                         epc: pc});
            m_wait = go && !er_ok && !(m_wait && pr);
            if (e_sw) status = e_sta;
        end
        @(negedge clk);
    endtask

    task automatic edge_on(input logic [3:0] r);
        req = r;
        tick();
        req = 4'd0;
    endtask

    initial begin
        rstn = 0; req = 0; status = 0; pc = 0; pr = 0; er = 0;
        @(negedge clk);
        tick();
        tick();
        rstn = 1;
        tick();
        chk("rst_depth", o_depth, 0);
        chk("rst_pend", o_pend, 0);

        // single IRQ1
        status = 32'h0F; pr = 1; pc = 32'h1000_0040;
        edge_on(4'b0010);
        tick();
        chk("single_early", o_take, 0);
        tick();
        chk("single_take", o_take, 1);
        chk("single_vec", o_vec, 32'h110);
        chk("single_sta", o_sta, 32'h2C);
        tick();
        chk("single_depth", o_depth, 1);
        er = 1; tick(); er = 0;
        chk("single_eret_sta", o_sta, 32'h0F);
        chk("single_ret_pc", o_ret, 32'h1000_0040);
        tick();
        chk("single_depth0", o_depth, 0);

        // priority IRQ2 over IRQ0
        pc = 32'h2000_0000;
        edge_on(4'b0101);
        tick();
        tick();
        chk("prio_vec", o_vec, 32'h120);
        chk("prio_sta", o_sta, 32'h48);
        tick();
        chk("prio_pend0", o_pend, 4'b0001);
        er = 1; tick(); er = 0;
        chk("prio_eret_sta", o_sta, 32'h0F);
        tick();
        tick();
        chk("prio_irq0_take", o_take, 1);
        chk("prio_irq0_sta", o_sta, 32'h1E);
        er = 1; tick(); er = 0;

        // nesting to depth 4
        for (int k = 0; k < 4; k++) begin
            pc = 32'h3000_0000 + 32'(k * 4);
            edge_on(4'(1 << k));
            tick();
            tick();
            chk("nest_take", o_take, 1);
        end
        chk("nest_last_sta", o_sta, 32'hF0);
        tick();
        chk("nest_depth4", o_depth, 4);
        er = 1;
        tick(); chk("nest_e1", o_sta, 32'h78);
        tick(); chk("nest_e2", o_sta, 32'h3C);
        tick(); chk("nest_e3", o_sta, 32'h1E);
        tick(); chk("nest_e4", o_sta, 32'h0F);
        chk("nest_e4_pc", o_ret, 32'h3000_0000);
        er = 0;
        tick();

        // stall then withdrawal
        pr = 0;
        edge_on(4'b0010);
        tick();
        tick(); chk("stall_irq", o_irq, 1);
        tick(); chk("stall_irq2", o_irq, 1);
        status = 32'h0D;
        tick();
        tick(); chk("wd_irq", o_irq, 0);
        chk("wd_take", o_take, 0);
        chk("wd_pend", o_pend, 4'b0010);
        status = 32'h0F; pr = 1;
        tick(); tick();
        chk("wd_late_take", o_take, 1);
        er = 1; tick(); er = 0;

        // eret and take in the same cycle
        edge_on(4'b0001);
        tick(); tick();
        pr = 0;
        edge_on(4'b0010);
        tick(); tick();
        er = 1; pr = 1; tick(); er = 0;
        chk("conf_done", o_done, 1);
        chk("conf_take", o_take, 0);
        tick();
        tick(); chk("conf_take2", o_take, 1);
        er = 1; tick(); tick(); er = 0;
        tick();
        er = 1; tick(); er = 0;
        chk("eret_d0_sw", o_sw, 0);
        chk("eret_d0_done", o_done, 0);

        // reset during a pending handshake
        pr = 0; status = 32'h0F;
        edge_on(4'b0100);
        tick(); tick();
        pr = 1; rstn = 0; tick();
        chk("rst_take", o_take, 0);
        rstn = 1; pr = 0; tick();
        chk("rst_pend2", o_pend, 0);
        chk("rst_depth2", o_depth, 0);
        chk("rst_irq", o_irq, 0);

        // random traffic
        status = 32'h0F;
        for (int i = 0; i < 600; i++) begin
            req  = 4'($urandom);
            pr   = 1'($urandom);
            er   = ($urandom % 4) == 0;
            pc   = $urandom;
            rstn = ($urandom % 64) != 0;
            if ($urandom % 16 == 0) status = 32'($urandom % 256);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mism);
        $finish;
    end

endmodule
